lcd_bus_responder: RTL and testbench

HD44780-compatible responder for the 8-bit character-LCD bus. It sits on the far end of the LCD write interface, where the panel normally sits, and shares its clock domain with the LCD driver FSM. It decodes every EN strobe, tracks the controller's instruction state, and mirrors the visible DDRAM of a 2×16 panel. It also extracts an "hh:mm:ss" string from line 1 into BCD digits, so the clock display can be checked end-to-end in simulation and on-chip.

---
 rtl/lcd_bus_responder.sv | 192 +++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// HD44780-style responder for the 8-bit LCD write bus: decodes EN strobes, tracks
// the init/instruction state, mirrors a 2x16 DDRAM and extracts "hh:mm:ss" from line 1.
module lcd_bus_responder #(
  parameter int SYNC_COUNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic             CLK_400Hz,
  input  logic             resetn,
  input  logic             LCD_ON,
  input  logic             LCD_RS,
  input  logic             LCD_EN,
  input  logic             LCD_RW,
  input  logic [7:0]       LCD_DATA,
  input  logic [4:0]       rd_addr,
  output logic [7:0]       rd_data,
  output logic             ready,
  output logic             disp_on,
  output logic             cursor_on,
  output logic             blink_on,
  output logic             entry_inc,
  output logic             entry_shift,
  output logic [6:0]       addr_cnt,
  output logic [3:0]       bcd_hrd1,
  output logic [3:0]       bcd_hrd0,
  output logic [3:0]       bcd_mind1,
  output logic [3:0]       bcd_mind0,
  output logic [3:0]       bcd_secd1,
  output logic [3:0]       bcd_secd0,
  output logic             time_valid,
  output logic             fmt_err,
  output logic [ERR_W-1:0] proto_err_cnt
);

  localparam int CNT_W = $clog2(SYNC_COUNT + 1);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_COUNT - 1);

  typedef enum logic [1:0] {S_WAIT, S_SYNC, S_READY} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] sync_cnt, sync_nx;

  logic       en_q, armed;
  logic       cap_rs, cap_rw;
  logic [7:0] cap_data;
  logic [7:0] ddram [32];
  logic       pend;

  // Bus protocol: fields are captured on every edge EN is high; the command acts
  // once, on the first edge EN is seen low again. armed blocks an EN level that
  // was already high when reset released from ever producing a strobe.
  logic strobe, is_fset, instr_rdy, data_wr, err_inc, time_ok;

  assign strobe    = en_q & ~LCD_EN & LCD_ON;
  assign is_fset   = strobe & ~cap_rw & ~cap_rs & (cap_data[7:4] == 4'h3);
  assign instr_rdy = strobe & ~cap_rw & ~cap_rs & (state == S_READY);
  assign data_wr   = strobe & ~cap_rw & cap_rs & (state == S_READY);
  assign err_inc   = (strobe & cap_rw) | (strobe & ~cap_rw & ~is_fset & (state != S_READY));
  assign ready     = (state == S_READY);
  assign rd_data   = ddram[rd_addr];

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  assign time_ok = is_digit(ddram[0]) & is_digit(ddram[1]) & (ddram[2] == 8'h3A) &
                   is_digit(ddram[3]) & is_digit(ddram[4]) & (ddram[5] == 8'h3A) &
                   is_digit(ddram[6]) & is_digit(ddram[7]);

  // Lines are 40 cells (0x00-0x27, 0x40-0x67); leaving a line, or stepping from an
  // out-of-range set-address value, lands on the other line's base.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    if (a[5:0] > 6'h27) return {~a[6], 6'h00};
    if (inc) return (a[5:0] == 6'h27) ? {~a[6], 6'h00} : a + 7'd1;
    return (a[5:0] == 6'h00) ? {~a[6], 6'h27} : a - 7'd1;
  endfunction

  always_ff @(posedge CLK_400Hz or negedge resetn) begin
    if (!resetn) begin
      state    <= S_WAIT;
      sync_cnt <= '0;
    end else begin
      state    <= state_nx;
      sync_cnt <= sync_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sync_nx  = sync_cnt;
    case (state)
      S_WAIT, S_SYNC: begin
        if (is_fset) begin
          sync_nx  = sync_cnt + 1'b1;
          state_nx = (sync_cnt == SYNC_LAST) ? S_READY : S_SYNC;
        end
      end
      S_READY: state_nx = S_READY;
      default: state_nx = S_WAIT;
    endcase
  end

  always_ff @(posedge CLK_400Hz or negedge resetn) begin
    if (!resetn) begin
      en_q     <= 1'b0;
      armed    <= 1'b0;
      cap_rs   <= 1'b0;
      cap_rw   <= 1'b0;
      cap_data <= 8'h00;
    end else begin
      en_q  <= LCD_EN & armed;
      armed <= armed | ~LCD_EN;
      if (LCD_EN) begin
        cap_rs   <= LCD_RS;
        cap_rw   <= LCD_RW;
        cap_data <= LCD_DATA;
      end
    end
  end

  always_ff @(posedge CLK_400Hz or negedge resetn) begin
    if (!resetn) begin
      proto_err_cnt <= '0;
    end else if (err_inc && (proto_err_cnt != {ERR_W{1'b1}})) begin
      proto_err_cnt <= proto_err_cnt + 1'b1;
    end
  end

  // Time extraction samples DDRAM the cycle after the write to 0x07 lands.
  always_ff @(posedge CLK_400Hz or negedge resetn) begin
    if (!resetn) begin
      pend       <= 1'b0;
      time_valid <= 1'b0;
      fmt_err    <= 1'b0;
      bcd_hrd1   <= 4'h0;
      bcd_hrd0   <= 4'h0;
      bcd_mind1  <= 4'h0;
      bcd_mind0  <= 4'h0;
      bcd_secd1  <= 4'h0;
      bcd_secd0  <= 4'h0;
    end else begin
      pend       <= data_wr & (addr_cnt == 7'h07);
      time_valid <= pend & time_ok;
      fmt_err    <= pend & ~time_ok;
      if (pend && time_ok) begin
        bcd_hrd1  <= ddram[0][3:0];
        bcd_hrd0  <= ddram[1][3:0];
        bcd_mind1 <= ddram[3][3:0];
        bcd_mind0 <= ddram[4][3:0];
        bcd_secd1 <= ddram[6][3:0];
        bcd_secd0 <= ddram[7][3:0];
      end
    end
  end

  always_ff @(posedge CLK_400Hz or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
      addr_cnt    <= 7'h00;
      entry_inc   <= 1'b1;
      entry_shift <= 1'b0;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
    end else if (data_wr) begin
      if (addr_cnt[5:4] == 2'b00) ddram[{addr_cnt[6], addr_cnt[3:0]}] <= cap_data;
      addr_cnt <= step_addr(addr_cnt, entry_inc);
    end else if (instr_rdy) begin
      // Highest set bit selects the instruction; 0x20-0x7F have no visible effect.
      if (cap_data[7]) begin
        addr_cnt <= cap_data[6:0];
      end else if (cap_data[6] || cap_data[5]) begin
        addr_cnt <= addr_cnt;
      end else if (cap_data[4]) begin
        if (!cap_data[3]) addr_cnt <= step_addr(addr_cnt, cap_data[2]);
      end else if (cap_data[3]) begin
        disp_on   <= cap_data[2];
        cursor_on <= cap_data[1];
        blink_on  <= cap_data[0];
      end else if (cap_data[2]) begin
        entry_inc   <= cap_data[1];
        entry_shift <= cap_data[0];
      end else if (cap_data[1]) begin
        addr_cnt <= 7'h00;
      end else if (cap_data[0]) begin
        for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
        addr_cnt  <= 7'h00;
        entry_inc <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: directed scenarios plus randomized strobes checked
// against a line/offset model of the panel kept here.
module tb_lcd_bus_responder;

  logic       clk = 1'b0;
  logic       resetn, lcd_on, lcd_rs, lcd_en, lcd_rw;
  logic [7:0] lcd_data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       ready, disp_on, cursor_on, blink_on, entry_inc, entry_shift;
  logic [6:0] addr_cnt;
  logic [3:0] bcd_hrd1, bcd_hrd0, bcd_mind1, bcd_mind0, bcd_secd1, bcd_secd0;
  logic       time_valid, fmt_err;
  logic [7:0] proto_err_cnt;

  lcd_bus_responder #(.SYNC_COUNT(3), .ERR_W(8)) dut (
    .CLK_400Hz(clk), .resetn(resetn), .LCD_ON(lcd_on), .LCD_RS(lcd_rs),
    .LCD_EN(lcd_en), .LCD_RW(lcd_rw), .LCD_DATA(lcd_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .ready(ready), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .entry_inc(entry_inc), .entry_shift(entry_shift),
    .addr_cnt(addr_cnt), .bcd_hrd1(bcd_hrd1), .bcd_hrd0(bcd_hrd0),
    .bcd_mind1(bcd_mind1), .bcd_mind0(bcd_mind0), .bcd_secd1(bcd_secd1),
    .bcd_secd0(bcd_secd0), .time_valid(time_valid), .fmt_err(fmt_err),
    .proto_err_cnt(proto_err_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int tv_seen = 0;
  int fe_seen = 0;

  // model state
  logic [7:0] mem [32];
  int         m_addr, m_fset, m_err;
  bit         m_ready, m_inc, m_shift, m_disp, m_cur, m_blink;
  logic [3:0] m_bcd [6];
  bit         exp_tv, exp_fe;
  int         pos_tab [6] = '{0, 1, 3, 4, 6, 7};
  logic [7:0] exp_q [$];

  logic [23:0] dut_bcd, mdl_bcd;
  logic [5:0]  dut_flags, mdl_flags;
  assign dut_bcd   = {bcd_hrd1, bcd_hrd0, bcd_mind1, bcd_mind0, bcd_secd1, bcd_secd0};
  assign mdl_bcd   = {m_bcd[0], m_bcd[1], m_bcd[2], m_bcd[3], m_bcd[4], m_bcd[5]};
  assign dut_flags = {ready, disp_on, cursor_on, blink_on, entry_inc, entry_shift};
  assign mdl_flags = {m_ready, m_disp, m_cur, m_blink, m_inc, m_shift};

  always @(negedge clk) begin
    if (time_valid === 1'b1) tv_seen++;
    if (fmt_err === 1'b1) fe_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic m_reset();
    for (int i = 0; i < 32; i++) mem[i] = 8'h20;
    for (int i = 0; i < 6; i++) m_bcd[i] = 4'h0;
    m_addr = 0; m_fset = 0; m_err = 0; m_ready = 0; m_inc = 1; m_shift = 0;
    m_disp = 0; m_cur = 0; m_blink = 0; exp_tv = 0; exp_fe = 0;
  endtask

  function automatic int m_step(int a, bit inc);
    int line = a / 64;
    int off  = a % 64;
    if (off > 39) return (1 - line) * 64;
    if (inc) return (off == 39) ? (1 - line) * 64 : a + 1;
    return (off == 0) ? (1 - line) * 64 + 39 : a - 1;
  endfunction

  task automatic m_exec(input bit rs, input bit rw, input logic [7:0] d);
    bit hit, ok;
    exp_tv = 0; exp_fe = 0;
    if (!lcd_on) return;
    if (rw) begin
      if (m_err < 255) m_err++;
      return;
    end
    if (!m_ready) begin
      if (!rs && d >= 8'h30 && d <= 8'h3F) begin
        m_fset++;
        if (m_fset >= 3) m_ready = 1;
      end else if (m_err < 255) m_err++;
      return;
    end
    if (rs) begin
      hit = (m_addr == 7);
      if ((m_addr % 64) < 16) mem[(m_addr / 64) * 16 + (m_addr % 16)] = d;
      m_addr = m_step(m_addr, m_inc);
      if (hit) begin
        ok = (mem[2] == 8'h3A) && (mem[5] == 8'h3A);
        for (int k = 0; k < 6; k++)
          if (mem[pos_tab[k]] < 8'h30 || mem[pos_tab[k]] > 8'h39) ok = 0;
        if (ok) begin
          for (int k = 0; k < 6; k++) m_bcd[k] = mem[pos_tab[k]][3:0];
          exp_tv = 1;
        end else exp_fe = 1;
      end
    end else if (d >= 8'h80) m_addr = d - 8'h80;
    else if (d >= 8'h20) m_addr = m_addr;
    else if (d >= 8'h10) begin
      if (!d[3]) m_addr = m_step(m_addr, d[2]);
    end else if (d >= 8'h08) begin
      m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
    end else if (d >= 8'h04) begin
      m_inc = d[1]; m_shift = d[0];
    end else if (d >= 8'h02) m_addr = 0;
    else if (d == 8'h01) begin
      for (int i = 0; i < 32; i++) mem[i] = 8'h20;
      m_addr = 0; m_inc = 1;
    end
  endtask

  // EN high for one edge, low for the next (execution edge), then one more edge
  // so any time-extract pulse from this strobe is visible on return.
  task automatic do_strobe(input bit rs, input bit rw, input logic [7:0] d);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
    @(posedge clk); #1;
    lcd_en = 1'b0;
    @(posedge clk);
    m_exec(rs, rw, d);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    resetn = 1'b0; lcd_en = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; lcd_on = 1'b1; lcd_rs = 0; lcd_rw = 0; lcd_en = 0;
    lcd_data = 8'h00; rd_addr = 5'd0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (dut_flags !== 6'b000010) begin bad++; $display("FAIL reset_flags got=%b exp=%b", dut_flags, 6'b000010); end
    total++; if (addr_cnt !== 7'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", addr_cnt); end
    total++; if (dut_bcd !== 24'h0) begin bad++; $display("FAIL reset_bcd got=%h exp=0", dut_bcd); end
    total++; if ({time_valid, fmt_err} !== 2'b00) begin bad++; $display("FAIL reset_pulses got=%b exp=00", {time_valid, fmt_err}); end
    total++; if (proto_err_cnt !== 8'h00) begin bad++; $display("FAIL reset_err got=%h exp=00", proto_err_cnt); end
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i); #1;
      total++; if (rd_data !== 8'h20) begin bad++; $display("FAIL reset_ddram[%0d] got=%h exp=20", i, rd_data); end
    end
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_preinit();
    do_strobe(1, 0, 8'h41);
    do_strobe(0, 0, 8'h0C);
    rd_addr = 5'd0; #1;
    total++; if (proto_err_cnt !== 8'd2) begin bad++; $display("FAIL preinit_err got=%0d exp=2", proto_err_cnt); end
    total++; if (rd_data !== 8'h20) begin bad++; $display("FAIL preinit_ddram0 got=%h exp=20", rd_data); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL preinit_ready got=%b exp=0", ready); end
  endtask

  task automatic test_init();
    string s = "12:34:56";
    int tv0;
    for (int i = 0; i < 4; i++) begin
      do_strobe(0, 0, 8'h38);
      total++; if (ready !== (i >= 2)) begin bad++; $display("FAIL init_ready[%0d] got=%b exp=%b", i, ready, i >= 2); end
    end
    do_strobe(0, 0, 8'h08);
    do_strobe(0, 0, 8'h01);
    do_strobe(0, 0, 8'h0C);
    do_strobe(0, 0, 8'h06);
    total++; if (dut_flags !== 6'b110010) begin bad++; $display("FAIL init_flags got=%b exp=%b", dut_flags, 6'b110010); end
    tv0 = tv_seen;
    for (int i = 0; i < 8; i++) do_strobe(1, 0, s[i]);
    total++; if (time_valid !== 1'b1) begin bad++; $display("FAIL init_time_valid got=%b exp=1", time_valid); end
    total++; if (addr_cnt !== 7'h08) begin bad++; $display("FAIL init_addr got=%h exp=08", addr_cnt); end
    total++; if (dut_bcd !== 24'h123456) begin bad++; $display("FAIL init_bcd got=%h exp=123456", dut_bcd); end
    do_strobe(0, 0, 8'h80);
    repeat (2) @(posedge clk); #1;
    total++; if (addr_cnt !== 7'h00) begin bad++; $display("FAIL init_home got=%h exp=00", addr_cnt); end
    total++; if (tv_seen - tv0 !== 1) begin bad++; $display("FAIL init_tv_pulses got=%0d exp=1", tv_seen - tv0); end
    total++; if (proto_err_cnt !== 8'd0) begin bad++; $display("FAIL init_err got=%0d exp=0", proto_err_cnt); end
  endtask

  task automatic test_inc_wrap();
    do_strobe(0, 0, 8'hA7);
    do_strobe(1, 0, 8'h41);
    total++; if (addr_cnt !== 7'h40) begin bad++; $display("FAIL incwrap_addr got=%h exp=40", addr_cnt); end
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i); #1;
      total++; if (rd_data !== mem[i]) begin bad++; $display("FAIL incwrap_ddram[%0d] got=%h exp=%h", i, rd_data, mem[i]); end
    end
    do_strobe(1, 0, 8'h42);
    rd_addr = 5'd16; #1;
    total++; if (rd_data !== 8'h42) begin bad++; $display("FAIL incwrap_ddram16 got=%h exp=42", rd_data); end
    total++; if (addr_cnt !== 7'h41) begin bad++; $display("FAIL incwrap_addr2 got=%h exp=41", addr_cnt); end
  endtask

  task automatic test_dec_wrap();
    do_strobe(0, 0, 8'h04);
    do_strobe(0, 0, 8'h80);
    do_strobe(1, 0, 8'h43);
    rd_addr = 5'd0; #1;
    total++; if (rd_data !== 8'h43) begin bad++; $display("FAIL decwrap_ddram0 got=%h exp=43", rd_data); end
    total++; if (addr_cnt !== 7'h67) begin bad++; $display("FAIL decwrap_addr got=%h exp=67", addr_cnt); end
    do_strobe(0, 0, 8'h06);
  endtask

  task automatic test_fmt_err();
    string s = "12-34:56";
    int fe0 = fe_seen;
    int tv0 = tv_seen;
    do_strobe(0, 0, 8'h80);
    for (int i = 0; i < 8; i++) do_strobe(1, 0, s[i]);
    total++; if ({fmt_err, time_valid} !== 2'b10) begin bad++; $display("FAIL fmt_pulse got=%b exp=10", {fmt_err, time_valid}); end
    repeat (2) @(posedge clk); #1;
    total++; if (fe_seen - fe0 !== 1) begin bad++; $display("FAIL fmt_pulses got=%0d exp=1", fe_seen - fe0); end
    total++; if (tv_seen - tv0 !== 0) begin bad++; $display("FAIL fmt_tv_pulses got=%0d exp=0", tv_seen - tv0); end
    total++; if (dut_bcd !== 24'h123456) begin bad++; $display("FAIL fmt_bcd_hold got=%h exp=123456", dut_bcd); end
  endtask

  task automatic test_rw();
    logic [7:0] e0 = proto_err_cnt;
    logic [6:0] a0 = addr_cnt;
    logic [5:0] f0 = dut_flags;
    do_strobe(0, 1, 8'h01);
    rd_addr = 5'd0; #1;
    total++; if (proto_err_cnt !== e0 + 8'd1) begin bad++; $display("FAIL rw_err got=%0d exp=%0d", proto_err_cnt, e0 + 8'd1); end
    total++; if (addr_cnt !== a0) begin bad++; $display("FAIL rw_addr got=%h exp=%h", addr_cnt, a0); end
    total++; if (dut_flags !== f0) begin bad++; $display("FAIL rw_flags got=%b exp=%b", dut_flags, f0); end
    total++; if (rd_data !== 8'h31) begin bad++; $display("FAIL rw_ddram0 got=%h exp=31", rd_data); end
  endtask

  task automatic test_lcd_off();
    logic [7:0] e0 = proto_err_cnt;
    logic [6:0] a0 = addr_cnt;
    lcd_on = 1'b0;
    do_strobe(1, 0, 8'h55);
    do_strobe(0, 1, 8'h00);
    do_strobe(0, 0, 8'h01);
    lcd_on = 1'b1;
    rd_addr = 5'd8; #1;
    total++; if (proto_err_cnt !== e0) begin bad++; $display("FAIL off_err got=%0d exp=%0d", proto_err_cnt, e0); end
    total++; if (addr_cnt !== a0) begin bad++; $display("FAIL off_addr got=%h exp=%h", addr_cnt, a0); end
    total++; if (rd_data !== mem[8]) begin bad++; $display("FAIL off_ddram8 got=%h exp=%h", rd_data, mem[8]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] c, e;
    do_strobe(0, 0, 8'hC8);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      c = 8'($urandom_range(8'h21, 8'h7E));
      lcd_rs = 1; lcd_rw = 0; lcd_data = c; lcd_en = 1'b1;
      @(posedge clk); #1;
      lcd_en = 1'b0;
      m_exec(1, 0, c);
      exp_q.push_back(c);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 5'(24 + i); #1;
      e = exp_q.pop_front();
      total++; if (rd_data !== e) begin bad++; $display("FAIL b2b_ddram[%0d] got=%h exp=%h", 24 + i, rd_data, e); end
    end
    total++; if (addr_cnt !== 7'h50) begin bad++; $display("FAIL b2b_addr got=%h exp=50", addr_cnt); end
    // long EN pulse with data changing while high: executes once with last value
    do_strobe(0, 0, 8'h80);
    @(posedge clk); #1;
    lcd_rs = 1; lcd_rw = 0; lcd_data = 8'h58; lcd_en = 1'b1;
    @(posedge clk); #1 lcd_data = 8'h5A;
    @(posedge clk); #1 lcd_data = 8'h59;
    @(posedge clk); #1 lcd_en = 1'b0;
    @(posedge clk); #1;
    m_exec(1, 0, 8'h59);
    rd_addr = 5'd0; #1;
    total++; if (rd_data !== 8'h59) begin bad++; $display("FAIL long_ddram0 got=%h exp=59", rd_data); end
    total++; if (addr_cnt !== 7'h01) begin bad++; $display("FAIL long_addr got=%h exp=01", addr_cnt); end
  endtask

  task automatic test_random();
    bit rs, rw;
    logic [7:0] d;
    int r, ra;
    for (int n = 0; n < 300; n++) begin
      rs = 0; rw = 0;
      r = $urandom_range(0, 19);
      if (r < 9 || r > 17) begin
        rs = 1;
        if ($urandom_range(0, 4) == 0) d = 8'($urandom_range(0, 255));
        else if ($urandom_range(0, 5) == 0) d = 8'h3A;
        else d = 8'(8'h30 + $urandom_range(0, 9));
      end else if (r < 11) d = 8'(8'h80 + $urandom_range(0, 7));
      else if (r == 11) d = 8'(8'h80 + $urandom_range(0, 127));
      else if (r == 12) d = 8'(8'h04 + $urandom_range(0, 3));
      else if (r == 13) d = 8'(8'h10 + $urandom_range(0, 15));
      else if (r == 14) d = 8'(8'h08 + $urandom_range(0, 7));
      else if (r == 15) d = 8'h02;
      else if (r == 16) d = 8'($urandom_range(0, 255));
      else begin rw = 1; rs = 1'($urandom_range(0, 1)); d = 8'($urandom_range(0, 255)); end
      do_strobe(rs, rw, d);
      ra = $urandom_range(0, 31);
      rd_addr = 5'(ra); #1;
      total++; if (dut_flags !== mdl_flags) begin bad++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, dut_flags, mdl_flags); end
      total++; if (addr_cnt !== 7'(m_addr)) begin bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, addr_cnt, 7'(m_addr)); end
      total++; if (proto_err_cnt !== 8'(m_err)) begin bad++; $display("FAIL rnd_err n=%0d got=%0d exp=%0d", n, proto_err_cnt, m_err); end
      total++; if ({time_valid, fmt_err} !== {exp_tv, exp_fe}) begin bad++; $display("FAIL rnd_pulse n=%0d got=%b exp=%b", n, {time_valid, fmt_err}, {exp_tv, exp_fe}); end
      total++; if (dut_bcd !== mdl_bcd) begin bad++; $display("FAIL rnd_bcd n=%0d got=%h exp=%h", n, dut_bcd, mdl_bcd); end
      total++; if (rd_data !== mem[ra]) begin bad++; $display("FAIL rnd_ddram[%0d] n=%0d got=%h exp=%h", ra, n, rd_data, mem[ra]); end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    lcd_rs = 0; lcd_rw = 1; lcd_data = 8'h01; lcd_en = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b0;
    m_reset();
    @(posedge clk); #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1 lcd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (dut_flags !== 6'b000010) begin bad++; $display("FAIL midrst_flags got=%b exp=%b", dut_flags, 6'b000010); end
    total++; if (addr_cnt !== 7'h00) begin bad++; $display("FAIL midrst_addr got=%h exp=00", addr_cnt); end
    total++; if (proto_err_cnt !== 8'h00) begin bad++; $display("FAIL midrst_err got=%0d exp=0", proto_err_cnt); end
    total++; if (dut_bcd !== 24'h0) begin bad++; $display("FAIL midrst_bcd got=%h exp=0", dut_bcd); end
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i); #1;
      total++; if (rd_data !== 8'h20) begin bad++; $display("FAIL midrst_ddram[%0d] got=%h exp=20", i, rd_data); end
    end
  endtask

  initial begin
    test_reset();
    test_preinit();
    apply_reset();
    test_init();
    test_inc_wrap();
    test_dec_wrap();
    test_fmt_err();
    test_rw();
    test_lcd_off();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
